// File: rtl/aec_pkg.sv
// aec_pkg: shared constants, op codes, state encodings and lexer
// helpers for the aec_param expression calculator.
package aec_pkg;

   localparam logic [7:0] ASC_EQ  = 8'h3D;
   localparam logic [7:0] ASC_LP  = 8'h28;
   localparam logic [7:0] ASC_RP  = 8'h29;
   localparam logic [7:0] ASC_MUL = 8'h2A;
   localparam logic [7:0] ASC_ADD = 8'h2B;
   localparam logic [7:0] ASC_SUB = 8'h2D;
   localparam logic [7:0] ASC_SP  = 8'h20;

   // Operators live in the low bits of a tagged token's value field.
   typedef logic [2:0] op_t;
   localparam op_t OP_LP  = 3'd0;
   localparam op_t OP_RP  = 3'd1;
   localparam op_t OP_MUL = 3'd2;
   localparam op_t OP_ADD = 3'd3;
   localparam op_t OP_SUB = 3'd4;

   typedef logic [2:0] state_t;
   localparam state_t BUFFER = 3'd0;
   localparam state_t IN2POS = 3'd1;
   localparam state_t POP    = 3'd2;
   localparam state_t CALC   = 3'd3;
   localparam state_t RESULT = 3'd4;
   localparam state_t DONE   = 3'd5;

   function automatic logic [1:0] prec(input op_t op);
      logic [1:0] p;
      case (op)
         OP_MUL:         p = 2'd2;
         OP_ADD, OP_SUB: p = 2'd1;
         default:        p = 2'd0;
      endcase
      return p;
   endfunction

   function automatic logic is_hex(input logic [7:0] c);
      return ((c >= 8'h30) && (c <= 8'h39)) ||
             ((c >= 8'h61) && (c <= 8'h66));
   endfunction

   function automatic logic [3:0] hex_val(input logic [7:0] c);
      return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
   endfunction

   // Returns {hit, op}.
   function automatic logic [3:0] op_dec(input logic [7:0] c);
      logic [3:0] r;
      case (c)
         ASC_LP:  r = {1'b1, OP_LP};
         ASC_RP:  r = {1'b1, OP_RP};
         ASC_MUL: r = {1'b1, OP_MUL};
         ASC_ADD: r = {1'b1, OP_ADD};
         ASC_SUB: r = {1'b1, OP_SUB};
         default: r = 4'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/aec_lifo.sv
// aec_lifo: saturating stack; pop_n removes up to two entries and a
// push in the same cycle lands on the new top.
module aec_lifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 32,
   parameter int PTR_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic [1:0]       pop_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] top,
   output logic [WIDTH-1:0] nxt,
   output logic [PTR_W-1:0] count
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] FULL = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] TWO  = PTR_W'(2);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] cnt_q;
   logic [PTR_W-1:0] cnt_d;
   logic [PTR_W-1:0] base;
   logic [PTR_W-1:0] pop_w;
   logic             wr_en;

   always_comb begin
      pop_w = PTR_W'(pop_n);
      base  = (pop_w > cnt_q) ? '0 : cnt_q - pop_w;
      wr_en = push && (base < FULL);
      cnt_d = wr_en ? base + ONE : base;
      if (clr) begin
         wr_en = 1'b0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[IDX_W'(base)] <= din;
   end

   assign top   = (cnt_q >= ONE) ? mem_q[IDX_W'(cnt_q - ONE)] : '0;
   assign nxt   = (cnt_q >= TWO) ? mem_q[IDX_W'(cnt_q - TWO)] : '0;
   assign count = cnt_q;

endmodule

// File: rtl/aec_param.sv
// aec_param: streaming infix calculator (lex, shunting-yard, evaluate).
// Define AEC_ERR_EN to build the error flag and drive the err port.
module aec_param
   import aec_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 32,
   parameter int PTR_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        ascii_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              err
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);
   localparam logic [PTR_W-1:0] TWO     = PTR_W'(2);

   typedef struct packed {
      logic              is_op;
      logic [DATA_W-1:0] val;
   } tok_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic              lit_q, lit_d;
   logic [PTR_W-1:0]  tcnt_q, tcnt_d;
   logic [PTR_W-1:0]  rd_q, rd_d;
   logic [PTR_W-1:0]  pcnt_q, pcnt_d;
   logic [PTR_W-1:0]  prd_q, prd_d;
   logic [DATA_W-1:0] res_q, res_d;

   tok_t tok_q [DEPTH];
   tok_t pf_q  [DEPTH];

   logic [PTR_W-1:0]  cnt_t;
   logic              err_set;
   logic              tw0_en, tw1_en;
   logic [IDX_W-1:0]  tw0_idx, tw1_idx;
   tok_t              tw0_dat, tw1_dat;
   logic              pw_en, pw_ok;
   logic [IDX_W-1:0]  pw_idx;
   tok_t              pw_dat;

   tok_t cur, ptok;
   op_t  cur_op, ptok_op;

   logic             in_fire, hex_hit, op_hit, eq_hit, sp_hit;
   logic [3:0]       od;
   logic [3:0]       hv;

   logic             o_push;
   logic [1:0]       o_pop_n;
   op_t              o_din, o_top, unused_o_nxt;
   logic [PTR_W-1:0] o_cnt;

   logic              v_push;
   logic [1:0]        v_pop_n;
   logic [DATA_W-1:0] v_din, v_top, v_nxt;
   logic [PTR_W-1:0]  v_cnt;

   logic stk_clr;

   assign in_ready = (state_q == BUFFER);
   assign valid    = (state_q == RESULT);
   assign result   = res_q;
   assign stk_clr  = (state_q == DONE);

   assign in_fire = in_valid && in_ready;
   assign od      = op_dec(ascii_in);
   assign hv      = hex_val(ascii_in);
   assign hex_hit = is_hex(ascii_in);
   assign op_hit  = od[3];
   assign eq_hit  = (ascii_in == ASC_EQ);
   assign sp_hit  = (ascii_in == ASC_SP);

   assign cur     = tok_q[IDX_W'(rd_q)];
   assign ptok    = pf_q[IDX_W'(prd_q)];
   assign cur_op  = cur.val[2:0];
   assign ptok_op = ptok.val[2:0];
   assign pw_idx  = IDX_W'(pcnt_q);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      lit_d   = lit_q;
      tcnt_d  = tcnt_q;
      rd_d    = rd_q;
      pcnt_d  = pcnt_q;
      prd_d   = prd_q;
      res_d   = res_q;
      cnt_t   = tcnt_q;
      err_set = 1'b0;
      tw0_en  = 1'b0;
      tw0_idx = '0;
      tw0_dat = '0;
      tw1_en  = 1'b0;
      tw1_idx = '0;
      tw1_dat = '0;
      pw_en   = 1'b0;
      pw_dat  = cur;
      o_push  = 1'b0;
      o_pop_n = 2'd0;
      o_din   = cur_op;
      v_push  = 1'b0;
      v_pop_n = 2'd0;
      v_din   = ptok.val;
      unique case (state_q)
         BUFFER: begin
            if (in_fire && hex_hit) begin
               acc_d = lit_q ? (acc_q << 4) | DATA_W'(hv)
                             : DATA_W'(hv);
               lit_d = 1'b1;
            end else if (in_fire) begin
               lit_d = 1'b0;
               if (lit_q) begin
                  if (cnt_t < DEPTH_P) begin
                     tw0_en  = 1'b1;
                     tw0_idx = IDX_W'(cnt_t);
                     tw0_dat = {1'b0, acc_q};
                     cnt_t   = cnt_t + ONE;
                  end else begin
                     err_set = 1'b1;
                  end
               end
               unique case (1'b1)
                  op_hit: begin
                     if (cnt_t < DEPTH_P) begin
                        tw1_en  = 1'b1;
                        tw1_idx = IDX_W'(cnt_t);
                        tw1_dat = {1'b1, DATA_W'(od[2:0])};
                        cnt_t   = cnt_t + ONE;
                     end else begin
                        err_set = 1'b1;
                     end
                  end
                  eq_hit:  state_d = IN2POS;
                  sp_hit:  ;
                  default: err_set = 1'b1;
               endcase
               tcnt_d = cnt_t;
            end
         end
         IN2POS: begin
            if (rd_q == tcnt_q) begin
               state_d = (o_cnt == '0) ? CALC : POP;
            end else if (!cur.is_op) begin
               pw_en = 1'b1;
               rd_d  = rd_q + ONE;
            end else begin
               unique case (cur_op)
                  OP_LP: begin
                     o_push = 1'b1;
                     rd_d   = rd_q + ONE;
                  end
                  OP_RP: begin
                     if (o_cnt == '0) begin
                        err_set = 1'b1;
                        rd_d    = rd_q + ONE;
                     end else if (o_top == OP_LP) begin
                        o_pop_n = 2'd1;
                        rd_d    = rd_q + ONE;
                     end else begin
                        o_pop_n = 2'd1;
                        pw_en   = 1'b1;
                        pw_dat  = {1'b1, DATA_W'(o_top)};
                     end
                  end
                  default: begin
                     if (o_cnt != '0 && o_top != OP_LP &&
                         prec(o_top) >= prec(cur_op)) begin
                        o_pop_n = 2'd1;
                        pw_en   = 1'b1;
                        pw_dat  = {1'b1, DATA_W'(o_top)};
                     end else begin
                        o_push = 1'b1;
                        rd_d   = rd_q + ONE;
                     end
                  end
               endcase
            end
         end
         POP: begin
            if (o_cnt == '0) begin
               state_d = CALC;
            end else begin
               o_pop_n = 2'd1;
               if (o_top == OP_LP) begin
                  err_set = 1'b1;
               end else begin
                  pw_en  = 1'b1;
                  pw_dat = {1'b1, DATA_W'(o_top)};
               end
               if (o_cnt == ONE) state_d = CALC;
            end
         end
         CALC: begin
            if (prd_q == pcnt_q) begin
               res_d   = v_top;
               state_d = RESULT;
            end else begin
               prd_d  = prd_q + ONE;
               v_push = 1'b1;
               if (ptok.is_op) begin
                  v_pop_n = 2'd2;
                  if (v_cnt < TWO) begin
                     err_set = 1'b1;
                     v_din   = '0;
                  end else begin
                     unique case (ptok_op)
                        OP_MUL:  v_din = v_nxt * v_top;
                        OP_ADD:  v_din = v_nxt + v_top;
                        default: v_din = v_nxt - v_top;
                     endcase
                  end
               end
            end
         end
         RESULT: begin
            if (out_ready) state_d = DONE;
         end
         DONE: begin
            state_d = BUFFER;
            acc_d   = '0;
            lit_d   = 1'b0;
            tcnt_d  = '0;
            rd_d    = '0;
            pcnt_d  = '0;
            prd_d   = '0;
         end
         default: state_d = BUFFER;
      endcase
      pw_ok = pw_en && (pcnt_q < DEPTH_P);
      if (pw_ok) pcnt_d = pcnt_q + ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BUFFER;
         acc_q   <= '0;
         lit_q   <= 1'b0;
         tcnt_q  <= '0;
         rd_q    <= '0;
         pcnt_q  <= '0;
         prd_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         lit_q   <= lit_d;
         tcnt_q  <= tcnt_d;
         rd_q    <= rd_d;
         pcnt_q  <= pcnt_d;
         prd_q   <= prd_d;
         res_q   <= res_d;
      end
   end

   always_ff @(posedge clk) begin
      if (tw0_en) tok_q[tw0_idx] <= tw0_dat;
      if (tw1_en) tok_q[tw1_idx] <= tw1_dat;
      if (pw_ok)  pf_q[pw_idx]   <= pw_dat;
   end

`ifdef AEC_ERR_EN
   logic err_flag_q, err_flag_d;
   logic rerr_q, rerr_d;

   // err is latched together with result so it stays stable while held.
   always_comb begin
      err_flag_d = err_flag_q | err_set;
      rerr_d     = rerr_q;
      if (state_q == CALC && prd_q == pcnt_q)
         rerr_d = err_flag_q | (v_cnt != ONE);
      if (state_q == DONE) err_flag_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_flag_q <= 1'b0;
         rerr_q     <= 1'b0;
      end else begin
         err_flag_q <= err_flag_d;
         rerr_q     <= rerr_d;
      end
   end

   assign err = rerr_q;
`else
   logic unused_err;
   assign unused_err = err_set;
   assign err        = 1'b0;
`endif

   aec_lifo #(
      .WIDTH (3),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_op_stk (
      .clk   (clk),
      .rst   (rst),
      .clr   (stk_clr),
      .push  (o_push),
      .pop_n (o_pop_n),
      .din   (o_din),
      .top   (o_top),
      .nxt   (unused_o_nxt),
      .count (o_cnt)
   );

   aec_lifo #(
      .WIDTH (DATA_W),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_val_stk (
      .clk   (clk),
      .rst   (rst),
      .clr   (stk_clr),
      .push  (v_push),
      .pop_n (v_pop_n),
      .din   (v_din),
      .top   (v_top),
      .nxt   (v_nxt),
      .count (v_cnt)
   );

endmodule

// File: tb/tb_aec_param.sv
// tb_aec_param: scoreboard bench for aec_param; expected results are
// queued as each expression is driven and checked when valid is taken.
module tb_aec_param;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 32;
`ifdef AEC_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        ascii_in;
   logic              in_valid;
   logic              in_ready;
   logic              valid;
   logic              out_ready;
   logic [DATA_W-1:0] result;
   logic              err;

   always #5 clk = ~clk;

   aec_param #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ascii_in  (ascii_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .valid     (valid),
      .out_ready (out_ready),
      .result    (result),
      .err       (err)
   );

   typedef struct {
      logic [DATA_W-1:0] res;
      logic              er;
      logic              chk_res;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   task automatic expect_res(input logic [DATA_W-1:0] r, input logic e,
                             input logic chk_r);
      exp_t x;
      x.res     = r;
      x.er      = ERR_EN ? e : 1'b0;
      x.chk_res = chk_r;
      sb_q.push_back(x);
   endtask

   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) begin
         int t;
         t        = 0;
         ascii_in = s[i];
         in_valid = 1'b1;
         @(negedge clk);
         while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
         end
         if (!in_ready) chk("in_ready_timeout", in_ready, 1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk("drain", sb_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!rst && valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk("spurious_valid", sb_q.size(), 1);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.chk_res) chk("result", result, e.res);
            chk("err", err, e.er);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      string long_s;
      int    t;
      rst       = 1'b1;
      ascii_in  = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_valid", valid, 0);
      chk("rst_result", result, 0);
      chk("rst_err", err, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // hold the result with out_ready low; stray input must be ignored
      out_ready = 1'b0;
      expect_res(16'h000B, 1'b0, 1'b1);
      send("3+4*2=");
      t = 0;
      while (t < 40) begin
         @(negedge clk);
         t++;
         if (valid) break;
      end
      chk("latency_le_20", (t - 1) <= 20, 1);
      ascii_in = "9";
      in_valid = 1'b1;
      repeat (5) begin
         chk("hold_valid", valid, 1);
         chk("hold_result", result, 16'h000B);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain(50);

      expect_res(16'h0015, 1'b0, 1'b1);
      expect_res(16'hFE01, 1'b0, 1'b1);
      send("(1+2)*(3+4)=");
      send("ff*ff=");
      drain(200);

      expect_res(16'hFFFD, 1'b0, 1'b1);
      send("2-5=");
      expect_res(16'h000E, 1'b0, 1'b1);
      send("10 - 1 - 1=");
      drain(200);

      expect_res(16'h0000, 1'b1, 1'b0);
      send("(1+2=");
      expect_res(16'h0000, 1'b1, 1'b0);
      send("1+)=");
      expect_res(16'h0000, 1'b1, 1'b0);
      send("1#2=");
      expect_res(16'h0000, 1'b1, 1'b1);
      send("=");
      drain(200);

      long_s = "";
      for (int i = 0; i < 20; i++) long_s = {long_s, "1+"};
      long_s = {long_s, "="};
      expect_res(16'h0000, 1'b1, 1'b0);
      send(long_s);
      drain(400);
      expect_res(16'h0002, 1'b0, 1'b1);
      send("1+1=");
      drain(200);

      // abort in IN2POS: no result may appear for the aborted expression
      send("1+2+3+4=");
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("busy_before_rst", in_ready, 0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_valid", valid, 0);
      expect_res(16'h002A, 1'b0, 1'b1);
      send("7*6=");
      drain(200);

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
